mips_main_controller: RTL and testbench
=======================================

MIPS_MAIN_CONTROLLER -- requirements
Module: mips_main_controller

Interface
REQ-001 The block SHALL declare no parameters; widths and encodings below are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have these ports:
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- alu_ctrl  out  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 100 nor, 111 slt.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- pc_en  out  1  PC load enable.
- iord  out  1  0 = instruction address, 1 = data address.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register load.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data.
- state  out  4  current FSM state (debug).

Function
REQ-004 The block SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-005 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE by op: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (treated as a nop).
- MEMADR -> MEMRD if op=100011, otherwise MEMWR.
- MEMRD -> MEMWB.
- RTEX -> RTWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, RTWB, BEQEX, ADDIWB, JEX -> FETCH.
- Encodings 12-15 -> FETCH.
REQ-006 Per-state asserted outputs (every unlisted output is 0, alu_src_b=00, pc_src=00):
- FETCH: ir_write, pc_write, alu_src_b=01, alu add.
- DECODE: alu_src_b=11, alu add.
- MEMADR: alu_src_a, alu_src_b=10, alu add.
- MEMRD: iord.
- MEMWB: reg_write, mem_to_reg.
- MEMWR: iord, mem_write.
- RTEX: alu_src_a, alu from funct.
- RTWB: reg_write, reg_dst.
- BEQEX: alu_src_a, alu sub, pc_src=01, branch.
- ADDIEX: alu_src_a, alu_src_b=10, alu add.
- ADDIWB: reg_write.
- JEX: pc_write, pc_src=10.
REQ-007 pc_en SHALL equal pc_write OR (branch AND zero); this is the only output that depends combinationally on an input (zero), with no extra latency.
REQ-008 In RTEX, alu_ctrl SHALL decode funct as follows: 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 100111 -> 100; 101010 -> 111; any other funct -> 010.
REQ-009 In states with no ALU activity, alu_ctrl SHALL be 010.
REQ-010 Instruction latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; unknown op 2 cycles.
REQ-011 op and funct SHALL be used only in DECODE, MEMADR and RTEX; they are stable in those states because ir_write is asserted only in FETCH.

Reset
REQ-012 While rst_n=0, state SHALL be FETCH, independent of clk.
REQ-013 While rst_n=0, pc_en, ir_write, mem_write and reg_write SHALL be forced to 0; all other outputs SHALL take their FETCH values.
REQ-014 After rst_n deasserts, the first rising clk edge SHALL complete FETCH.
REQ-015 Asserting rst_n mid-instruction SHALL abort that instruction immediately, with no pending write completing.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Reset, then op=100011 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
- op=000000, funct=101010 -> in state 6 alu_ctrl=111; in state 7 reg_write=1 and reg_dst=1; back to 0.
- op=000100 with zero=1 in BEQEX -> pc_en=1, pc_src=01, alu_ctrl=110; with zero=0 -> pc_en=0; both return to FETCH.
- op=101011 -> sequence 0,1,2,5,0; mem_write=1 and iord=1 in state 5; reg_write is never asserted.
- op=111111 -> DECODE returns to FETCH; no write enable asserted in either cycle.
- rst_n pulsed low during state 4 (lw) -> state=0 asynchronously; reg_write=0 at once and throughout reset.

Source files
------------

// File: rtl/mips_main_controller_if.sv
// Bundle between the multicycle MIPS datapath and its main controller:
// instruction fields and ALU zero flag in, datapath control strobes out.
interface mips_main_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [3:0] state;

    modport master (
        output op, funct, zero,
        input  alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, state
    );

    modport slave (
        input  op, funct, zero,
        output alu_ctrl, alu_src_a, alu_src_b, pc_src, pc_en, iord,
               mem_write, ir_write, reg_write, reg_dst, mem_to_reg, state
    );
endinterface

// File: rtl/mips_main_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute,
// with pc_en the only output that also looks at the live ALU zero flag.
module mips_main_controller (
    input  logic                          clk,
    input  logic                          rst_n,
    mips_main_controller_if.slave         bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Unrecognised funct codes fall back to add so the datapath stays benign.
    function automatic logic [2:0] decode_funct(input logic [5:0] funct);
        logic [2:0] res;
        case (funct)
            6'b100000: res = ALU_ADD;
            6'b100010: res = ALU_SUB;
            6'b100100: res = ALU_AND;
            6'b100101: res = ALU_OR;
            6'b100111: res = ALU_NOR;
            6'b101010: res = ALU_SLT;
            default:   res = ALU_ADD;
        endcase
        return res;
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_iord;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; unused encodings recover to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LW) begin
                    w_next = S_MEMRD;
                end else begin
                    w_next = S_MEMWR;
                end
            end
            S_MEMRD:  w_next = S_MEMWB;
            S_RTEX:   w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Moore output decode from the current state.
    always_comb begin
        w_alu_ctrl   = ALU_ADD;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
            end
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: w_iord = 1'b1;
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_RTEX: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = decode_funct(bus.funct);
            end
            S_RTWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = ALU_SUB;
                w_pc_src    = 2'b01;
                w_branch    = 1'b1;
            end
            S_ADDIWB: w_reg_write = 1'b1;
            S_JEX: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b10;
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Write enables are gated by rst_n so nothing commits while reset is held.
    assign bus.pc_en      = rst_n & (w_pc_write | (w_branch & bus.zero));
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.mem_write  = rst_n & w_mem_write;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.alu_ctrl   = w_alu_ctrl;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.iord       = w_iord;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_mips_main_controller.sv
// Directed bench for the multicycle MIPS main controller: walks each
// instruction class through its state sequence and checks decoded controls.
module tb_mips_main_controller;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mips_main_controller_if bus ();

    mips_main_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;

        // Reset: FETCH values with write enables forced low
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", {4'd0, bus.state}, 8'd0);
        chk("rst_ir_write", {7'd0, bus.ir_write}, 8'd0);
        chk("rst_pc_en", {7'd0, bus.pc_en}, 8'd0);
        chk("rst_alu_src_b", {6'd0, bus.alu_src_b}, 8'd1);
        chk("rst_alu_ctrl", {5'd0, bus.alu_ctrl}, 8'd2);

        // lw: 0,1,2,3,4,0
        rst_n = 1'b1;
        #1;
        chk("lw_s0", {4'd0, bus.state}, 8'd0);
        chk("lw_s0_ir_write", {7'd0, bus.ir_write}, 8'd1);
        chk("lw_s0_pc_en", {7'd0, bus.pc_en}, 8'd1);
        step();
        chk("lw_s1", {4'd0, bus.state}, 8'd1);
        chk("lw_s1_alu_src_b", {6'd0, bus.alu_src_b}, 8'd3);
        chk("lw_s1_reg_write", {7'd0, bus.reg_write}, 8'd0);
        step();
        chk("lw_s2", {4'd0, bus.state}, 8'd2);
        chk("lw_s2_srcs", {5'd0, bus.alu_src_a, bus.alu_src_b}, 8'b110);
        step();
        chk("lw_s3", {4'd0, bus.state}, 8'd3);
        chk("lw_s3_iord", {7'd0, bus.iord}, 8'd1);
        chk("lw_s3_wr", {6'd0, bus.reg_write, bus.mem_to_reg}, 8'd0);
        step();
        chk("lw_s4", {4'd0, bus.state}, 8'd4);
        chk("lw_s4_wr", {6'd0, bus.reg_write, bus.mem_to_reg}, 8'b11);
        step();
        chk("lw_back", {4'd0, bus.state}, 8'd0);
        chk("lw_back_wr", {6'd0, bus.reg_write, bus.mem_to_reg}, 8'd0);

        // R-type slt
        bus.op    = 6'b000000;
        bus.funct = 6'b101010;
        step();
        step();
        chk("rt_s6", {4'd0, bus.state}, 8'd6);
        chk("rt_slt_alu", {5'd0, bus.alu_ctrl}, 8'b111);
        chk("rt_s6_src_a", {7'd0, bus.alu_src_a}, 8'd1);
        step();
        chk("rt_s7", {4'd0, bus.state}, 8'd7);
        chk("rt_s7_wr", {6'd0, bus.reg_write, bus.reg_dst}, 8'b11);
        step();
        chk("rt_back", {4'd0, bus.state}, 8'd0);

        // R-type sub and an unknown funct
        bus.funct = 6'b100010;
        step();
        step();
        chk("rt_sub_alu", {5'd0, bus.alu_ctrl}, 8'b110);
        bus.funct = 6'b100101;
        #1;
        chk("rt_or_alu", {5'd0, bus.alu_ctrl}, 8'b001);
        bus.funct = 6'b111000;
        #1;
        chk("rt_unk_alu", {5'd0, bus.alu_ctrl}, 8'b010);
        step();
        step();
        chk("rt2_back", {4'd0, bus.state}, 8'd0);

        // beq with zero toggled while in BEQEX
        bus.op   = 6'b000100;
        bus.zero = 1'b1;
        step();
        chk("beq_s1_pc_en", {7'd0, bus.pc_en}, 8'd0);
        step();
        chk("beq_s8", {4'd0, bus.state}, 8'd8);
        chk("beq_taken_pc_en", {7'd0, bus.pc_en}, 8'd1);
        chk("beq_pc_src", {6'd0, bus.pc_src}, 8'b01);
        chk("beq_alu", {5'd0, bus.alu_ctrl}, 8'b110);
        bus.zero = 1'b0;
        #1;
        chk("beq_nottaken_pc_en", {7'd0, bus.pc_en}, 8'd0);
        step();
        chk("beq_back", {4'd0, bus.state}, 8'd0);

        // sw: 0,1,2,5,0
        bus.op = 6'b101011;
        chk("sw_s0_reg_write", {7'd0, bus.reg_write}, 8'd0);
        step();
        chk("sw_s1_reg_write", {7'd0, bus.reg_write}, 8'd0);
        step();
        chk("sw_s2", {4'd0, bus.state}, 8'd2);
        chk("sw_s2_reg_write", {7'd0, bus.reg_write}, 8'd0);
        step();
        chk("sw_s5", {4'd0, bus.state}, 8'd5);
        chk("sw_s5_ctl", {5'd0, bus.mem_write, bus.iord, bus.reg_write}, 8'b110);
        step();
        chk("sw_back", {4'd0, bus.state}, 8'd0);
        chk("sw_back_mem_write", {7'd0, bus.mem_write}, 8'd0);

        // addi: 0,1,9,10,0
        bus.op = 6'b001000;
        step();
        step();
        chk("addi_s9", {4'd0, bus.state}, 8'd9);
        chk("addi_s9_srcs", {5'd0, bus.alu_src_a, bus.alu_src_b}, 8'b110);
        step();
        chk("addi_s10", {4'd0, bus.state}, 8'd10);
        chk("addi_s10_wr", {6'd0, bus.reg_write, bus.reg_dst}, 8'b10);
        step();
        chk("addi_back", {4'd0, bus.state}, 8'd0);

        // j: 0,1,11,0
        bus.op = 6'b000010;
        step();
        step();
        chk("j_s11", {4'd0, bus.state}, 8'd11);
        chk("j_ctl", {5'd0, bus.pc_en, bus.pc_src}, 8'b110);
        step();
        chk("j_back", {4'd0, bus.state}, 8'd0);

        // Unknown op: DECODE straight back to FETCH
        bus.op = 6'b111111;
        chk("nop_s0_wr", {6'd0, bus.mem_write, bus.reg_write}, 8'd0);
        step();
        chk("nop_s1", {4'd0, bus.state}, 8'd1);
        chk("nop_s1_wr", {5'd0, bus.mem_write, bus.reg_write, bus.ir_write}, 8'd0);
        step();
        chk("nop_back", {4'd0, bus.state}, 8'd0);

        // Reset asserted mid-lw in MEMWB
        bus.op = 6'b100011;
        step();
        step();
        step();
        step();
        chk("abort_s4", {4'd0, bus.state}, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_state", {4'd0, bus.state}, 8'd0);
        chk("abort_reg_write", {7'd0, bus.reg_write}, 8'd0);
        step();
        chk("abort_hold_state", {4'd0, bus.state}, 8'd0);
        chk("abort_hold_wr", {5'd0, bus.reg_write, bus.ir_write, bus.pc_en}, 8'd0);
        rst_n = 1'b1;
        #1;
        chk("abort_release_ir", {7'd0, bus.ir_write}, 8'd1);
        step();
        chk("abort_restart_s1", {4'd0, bus.state}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
